arm_shift_pipe: RTL and testbench
=================================

Name: arm_shift_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle operand-2 shifter.
- Computes the ARM data-processing operand 2 (immediate rotate, or LSL/LSR/ASR/ROR/RRX by immediate or register amount) together with shifter carry-out.
- Registered stages with valid/ready handshake let the multi-cycle and pipelined cores insert it between register read and ALU without combinational timing loss.
- Carries an opaque tag so results stay matched to their instructions.

Parameters:
- WIDTH, 32, datapath width; legal values 8/16/32/64; SW = log2(WIDTH).
- PIPE_STAGES, 2, register stages; 1 = decode+shift in one stage, 2 = decode stage then shift stage.
- TAG_W, 4, width of the tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept this cycle.
- in_imm  in  1  1 = immediate form (instr bit 25).
- in_regamt  in  1  1 = amount from register (instr bit 4); ignored when in_imm=1.
- in_sh  in  2  0 LSL, 1 LSR, 2 ASR, 3 ROR.
- in_shamt  in  5  immediate shift amount; only [SW-1:0] used.
- in_rs  in  8  register shift amount (Rs[7:0]).
- in_rm  in  WIDTH  operand Rm.
- in_imm8  in  8  immediate byte.
- in_rot  in  4  immediate rotate; rotation = 2*in_rot mod WIDTH.
- in_cin  in  1  current C flag.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  shifted operand.
- out_cout  out  1  shifter carry-out.
- out_tag  out  TAG_W  tag of the result.
- out_n  out  1  out_data MSB (see Optional Feature).
- out_z  out  1  out_data == 0 (see Optional Feature).

Behaviour:
- Reset, asynchronous: all stage valid bits 0; out_valid=0, out_data=0, out_cout=0, out_tag=0, out_n=0, out_z=0. in_ready=1 from the first cycle after reset deasserts. Reset mid-operation discards all in-flight entries; nothing is emitted.
- Handshake:
  - Transfer on in_valid&in_ready, or on out_valid&out_ready.
  - Each stage loads when it is empty or its successor accepts this cycle; in_ready = !stage1_valid | stage1_advances.
  - Full throughput is one op per cycle, no bubbles, when out_ready is held 1.
  - Latency is exactly PIPE_STAGES cycles from acceptance to out_valid.
  - Held outputs stay stable while out_valid & !out_ready.
  - Simultaneous accept and emit in the same cycle is legal.
- Immediate form (in_imm=1):
  - out_data = zero-extended in_imm8 rotated right by 2*in_rot.
  - out_cout = in_cin if in_rot==0, else out_data[WIDTH-1].
- Immediate amount, n = in_shamt[SW-1:0]:
  - LSL n: n=0 passes Rm with cout=cin; otherwise cout=Rm[WIDTH-n].
  - LSR n: n=0 means LSR #WIDTH, giving 0 with cout=Rm[WIDTH-1]; otherwise cout=Rm[n-1].
  - ASR n: n=0 means ASR #WIDTH, giving all bits = Rm[WIDTH-1] with cout=Rm[WIDTH-1]; otherwise cout=Rm[n-1].
  - ROR n: n=0 means RRX, giving {cin, Rm[WIDTH-1:1]} with cout=Rm[0]; otherwise cout=result MSB.
- Register amount, a = in_rs (0..255):
  - a=0: any op passes Rm with cout=cin.
  - LSL: a<WIDTH normal; a==WIDTH gives 0 with cout=Rm[0]; a>WIDTH gives 0 with cout=0.
  - LSR: a==WIDTH gives 0 with cout=Rm[WIDTH-1]; a>WIDTH gives 0 with cout=0.
  - ASR: a>=WIDTH gives sign fill with cout=Rm[WIDTH-1].
  - ROR: uses a mod WIDTH; if that is 0 (and a!=0), result is Rm with cout=Rm[WIDTH-1].
- PIPE_STAGES=2: stage 1 registers the decoded op, the effective amount (0..WIDTH) and the special-case flags; stage 2 runs the log-shifter and carry select.
- out_tag always equals the in_tag of the same op.

Optional Feature:
- Macro ARM_SHIFT_FLAGS_EN.
- Defined: out_n and out_z are registered alongside out_data and are valid with out_valid.
- Undefined: out_n and out_z are tied to 0 and no flag logic is synthesised.

Test Plan (WIDTH=32, PIPE_STAGES=2):
- Immediate rotate: imm8=0xFF, rot=4, cin=0 -> out_data=0xFF000000, cout=1, out_valid exactly 2 cycles after accept.
- Immediate specials on Rm=0x80000001, cin=1: LSR #0 -> 0x00000000, cout=1. ASR #0 -> 0xFFFFFFFF, cout=1. ROR #0 -> 0xC0000000, cout=1.
- Register amounts on Rm=0x00000003, cin=0: LSL rs=32 -> 0, cout=1. LSL rs=33 -> 0, cout=0. ROR rs=64 -> 0x00000003, cout=0. LSL rs=0 with cin=1 -> 0x00000003, cout=1.
- Back-pressure: stream 6 tagged ops (tags 0..5) while out_ready is low for 3 cycles mid-stream -> in_ready drops once both stages fill; results emerge in order 0..5, none lost or duplicated; outputs stable while stalled.
- Reset mid-flight: assert reset with 2 ops in flight -> out_valid=0 immediately; no stale result after release; the next op completes normally.
- Flags (with ARM_SHIFT_FLAGS_EN): LSR rs=40 on 0xFFFFFFFF -> out_z=1, out_n=0. ASR #1 on 0x80000000 -> out_n=1, out_z=0.

Source files
------------

// File: rtl/arm_shift_pipe_if.sv
// arm_shift_pipe_if: request/response bundle for the pipelined operand-2 shifter.
// The master side issues requests and consumes results; the slave side is the shifter.
interface arm_shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic             in_imm;
  logic             in_regamt;
  logic [1:0]       in_sh;
  logic [4:0]       in_shamt;
  logic [7:0]       in_rs;
  logic [WIDTH-1:0] in_rm;
  logic [7:0]       in_imm8;
  logic [3:0]       in_rot;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
  logic             out_n;
  logic             out_z;

  modport master (
    output in_valid, in_imm, in_regamt, in_sh, in_shamt, in_rs, in_rm,
           in_imm8, in_rot, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_tag, out_n, out_z
  );

  modport slave (
    input  in_valid, in_imm, in_regamt, in_sh, in_shamt, in_rs, in_rm,
           in_imm8, in_rot, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_tag, out_n, out_z
  );
endinterface

// File: rtl/arm_shift_pipe.sv
// arm_shift_pipe: pipelined ARM data-processing operand-2 shifter with carry-out.
// Decode maps every form (immediate rotate, shift by immediate, shift by register)
// onto a common {op, amount 0..WIDTH, rrx, over} record; the execute step is one
// shifter plus carry select. PIPE_STAGES=2 registers the decoded record first.
// Optional macro ARM_SHIFT_FLAGS_EN: registers out_n/out_z alongside out_data;
// when undefined both are tied to 0.
module arm_shift_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  arm_shift_pipe_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0]  SH_LSL = 2'd0;
  localparam logic [1:0]  SH_LSR = 2'd1;
  localparam logic [1:0]  SH_ASR = 2'd2;
  localparam logic [1:0]  SH_ROR = 2'd3;

  localparam logic [SW:0] AMT_W  = (SW+1)'(WIDTH);
  localparam logic [SW:0] AMT_1  = (SW+1)'(1);
  localparam logic [8:0]  RS_W   = 9'(WIDTH);

  // Decoded operation: amt==0 means pass source with cout=cin; over forces 0/0.
  typedef struct packed {
    logic [1:0]       op;
    logic [SW:0]      amt;
    logic             rrx;
    logic             over;
    logic             cin;
    logic [WIDTH-1:0] src;
    logic [TAG_W-1:0] tag;
  } dec_t;

  // Execute a decoded op; returns {cout, data}.
  function automatic logic [WIDTH:0] shift_exec(input dec_t d);
    logic [WIDTH-1:0] res;
    logic             co;
    logic [SW:0]      ldiff;
    logic [SW:0]      rdiff;
    logic [SW-1:0]    li;
    logic [SW-1:0]    ri;
    ldiff = AMT_W - d.amt;
    rdiff = d.amt - AMT_1;
    li    = ldiff[SW-1:0];
    ri    = rdiff[SW-1:0];
    res   = d.src;
    co    = d.cin;
    if (d.over) begin
      res = '0;
      co  = 1'b0;
    end else if (d.rrx) begin
      res = {d.cin, d.src[WIDTH-1:1]};
      co  = d.src[0];
    end else if (d.amt == '0) begin
      res = d.src;
      co  = d.cin;
    end else begin
      case (d.op)
        SH_LSL: begin
          res = d.src << d.amt;
          co  = d.src[li];
        end
        SH_LSR: begin
          res = d.src >> d.amt;
          co  = d.src[ri];
        end
        SH_ASR: begin
          res = WIDTH'($signed(d.src) >>> d.amt);
          co  = d.src[ri];
        end
        SH_ROR: begin
          // amt==WIDTH rotates fully: result is src, cout is src MSB.
          res = (d.src >> d.amt) | (d.src << (AMT_W - d.amt));
          co  = d.src[ri];
        end
        default: begin
          res = d.src;
          co  = d.cin;
        end
      endcase
    end
    return {co, res};
  endfunction

  logic [SW-1:0] w_n;
  logic [SW-1:0] w_rot2;
  logic [SW-1:0] w_rsm;
  dec_t          w_dec;

  assign w_n    = SW'(bus.in_shamt);
  assign w_rot2 = SW'({bus.in_rot, 1'b0});
  assign w_rsm  = SW'(bus.in_rs);

  // Decode the request into the common shift record.
  always_comb begin
    w_dec      = '0;
    w_dec.cin  = bus.in_cin;
    w_dec.tag  = bus.in_tag;
    w_dec.src  = bus.in_rm;
    w_dec.op   = bus.in_sh;
    if (bus.in_imm) begin
      w_dec.op  = SH_ROR;
      w_dec.src = {{(WIDTH-8){1'b0}}, bus.in_imm8};
      if (bus.in_rot == 4'd0) begin
        w_dec.amt = '0;
      end else if (w_rot2 == '0) begin
        w_dec.amt = AMT_W;
      end else begin
        w_dec.amt = {1'b0, w_rot2};
      end
    end else if (!bus.in_regamt) begin
      case (bus.in_sh)
        SH_LSL: w_dec.amt = {1'b0, w_n};
        SH_LSR,
        SH_ASR: w_dec.amt = (w_n == '0) ? AMT_W : {1'b0, w_n};
        SH_ROR: begin
          if (w_n == '0) begin
            w_dec.rrx = 1'b1;
          end else begin
            w_dec.amt = {1'b0, w_n};
          end
        end
        default: w_dec.amt = '0;
      endcase
    end else if (bus.in_rs == 8'd0) begin
      w_dec.amt = '0;
    end else begin
      case (bus.in_sh)
        SH_LSL,
        SH_LSR: begin
          if ({1'b0, bus.in_rs} > RS_W) begin
            w_dec.over = 1'b1;
          end else begin
            w_dec.amt = bus.in_rs[SW:0];
          end
        end
        SH_ASR: begin
          if ({1'b0, bus.in_rs} >= RS_W) begin
            w_dec.amt = AMT_W;
          end else begin
            w_dec.amt = bus.in_rs[SW:0];
          end
        end
        SH_ROR: w_dec.amt = (w_rsm == '0) ? AMT_W : {1'b0, w_rsm};
        default: w_dec.amt = '0;
      endcase
    end
  end

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_cout;
  logic [TAG_W-1:0] r_out_tag;
  logic             w_out_adv;
  logic             w_in_ready;
  logic             w_exec_valid;
  dec_t             w_exec_in;
  logic [WIDTH:0]   w_res;

  assign w_out_adv = !r_out_valid | bus.out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic r_s1_valid;
      dec_t r_s1;

      assign w_in_ready   = !r_s1_valid | w_out_adv;
      assign w_exec_in    = r_s1;
      assign w_exec_valid = r_s1_valid;

      // Decode stage register: loads when empty or draining into the output stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1_valid <= 1'b0;
          r_s1       <= '0;
        end else if (w_in_ready) begin
          r_s1_valid <= bus.in_valid;
          if (bus.in_valid) begin
            r_s1 <= w_dec;
          end
        end
      end
    end else begin : g_one
      assign w_in_ready   = w_out_adv;
      assign w_exec_in    = w_dec;
      assign w_exec_valid = bus.in_valid;
    end
  endgenerate

  assign w_res = shift_exec(w_exec_in);

  // Output stage: holds its result until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cout  <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_out_adv) begin
      r_out_valid <= w_exec_valid;
      if (w_exec_valid) begin
        r_out_data <= w_res[WIDTH-1:0];
        r_out_cout <= w_res[WIDTH];
        r_out_tag  <= w_exec_in.tag;
      end
    end
  end

`ifdef ARM_SHIFT_FLAGS_EN
  logic r_out_n;
  logic r_out_z;

  // N/Z flags captured in lock-step with the output data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_n <= 1'b0;
      r_out_z <= 1'b0;
    end else if (w_out_adv && w_exec_valid) begin
      r_out_n <= w_res[WIDTH-1];
      r_out_z <= (w_res[WIDTH-1:0] == '0);
    end
  end

  assign bus.out_n = r_out_n;
  assign bus.out_z = r_out_z;
`else
  assign bus.out_n = 1'b0;
  assign bus.out_z = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_arm_shift_pipe.sv
// tb_arm_shift_pipe: directed, table-driven check of arm_shift_pipe (WIDTH=32, 2 stages).
module tb_arm_shift_pipe;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int NV = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arm_shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  arm_shift_pipe #(.WIDTH(W), .PIPE_STAGES(2), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        imm;
    logic        regamt;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic [7:0]  rs;
    logic [31:0] rm;
    logic [7:0]  imm8;
    logic [3:0]  rot;
    logic        cin;
    logic [31:0] exp_data;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic imm, input logic regamt, input logic [1:0] sh,
                              input logic [4:0] shamt, input logic [7:0] rs, input logic [31:0] rm,
                              input logic [7:0] imm8, input logic [3:0] rot, input logic cin,
                              input logic [31:0] ed, input logic ec);
    vec_t v;
    v.imm = imm; v.regamt = regamt; v.sh = sh; v.shamt = shamt; v.rs = rs; v.rm = rm;
    v.imm8 = imm8; v.rot = rot; v.cin = cin; v.exp_data = ed; v.exp_cout = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic [3:0] tag);
    bus.in_imm    = v.imm;
    bus.in_regamt = v.regamt;
    bus.in_sh     = v.sh;
    bus.in_shamt  = v.shamt;
    bus.in_rs     = v.rs;
    bus.in_rm     = v.rm;
    bus.in_imm8   = v.imm8;
    bus.in_rot    = v.rot;
    bus.in_cin    = v.cin;
    bus.in_tag    = tag;
  endtask

  // Push one op, wait for its result and compare everything including latency.
  task automatic run_vec(input vec_t v, input logic [3:0] tag, input string name);
    int wc;
    int lat;
    logic en;
    logic ez;
`ifdef ARM_SHIFT_FLAGS_EN
    en = v.exp_data[31];
    ez = (v.exp_data == 32'd0);
`else
    en = 1'b0;
    ez = 1'b0;
`endif
    @(negedge clk);
    apply(v, tag);
    bus.in_valid = 1'b1;
    #1;
    wc = 0;
    while (!bus.in_ready && wc < 10) begin
      @(negedge clk);
      #1;
      wc++;
    end
    chk({name, "_accept"}, {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"},  64'(lat), 64'd2);
    chk({name, "_data"}, {32'd0, bus.out_data}, {32'd0, v.exp_data});
    chk({name, "_cout"}, {63'd0, bus.out_cout}, {63'd0, v.exp_cout});
    chk({name, "_tag"},  {60'd0, bus.out_tag}, {60'd0, tag});
    chk({name, "_n"},    {63'd0, bus.out_n}, {63'd0, en});
    chk({name, "_z"},    {63'd0, bus.out_z}, {63'd0, ez});
  endtask

  initial begin
    int sent;
    int rx;
    logic saw_block;
    vec_t bp;

    vecs[0]  = mk(1'b1, 1'b0, 2'd0, 5'd0, 8'd0,   32'h0,        8'hFF, 4'd4, 1'b0, 32'hFF000000, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 2'd0, 5'd0, 8'd0,   32'h0,        8'h01, 4'd0, 1'b1, 32'h00000001, 1'b1);
    vecs[2]  = mk(1'b1, 1'b0, 2'd0, 5'd0, 8'd0,   32'h0,        8'h01, 4'd1, 1'b1, 32'h40000000, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 2'd1, 5'd0, 8'd0,   32'h80000001, 8'h00, 4'd0, 1'b1, 32'h00000000, 1'b1);
    vecs[4]  = mk(1'b0, 1'b0, 2'd2, 5'd0, 8'd0,   32'h80000001, 8'h00, 4'd0, 1'b1, 32'hFFFFFFFF, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 2'd3, 5'd0, 8'd0,   32'h80000001, 8'h00, 4'd0, 1'b1, 32'hC0000000, 1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 2'd0, 5'd0, 8'd0,   32'h80000001, 8'h00, 4'd0, 1'b0, 32'h80000001, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 2'd0, 5'd1, 8'd0,   32'h80000001, 8'h00, 4'd0, 1'b0, 32'h00000002, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 2'd1, 5'd4, 8'd0,   32'h0000001F, 8'h00, 4'd0, 1'b0, 32'h00000001, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 2'd2, 5'd4, 8'd0,   32'h80000010, 8'h00, 4'd0, 1'b0, 32'hF8000001, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 2'd3, 5'd8, 8'd0,   32'h12345678, 8'h00, 4'd0, 1'b0, 32'h78123456, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 2'd0, 5'd0, 8'd32,  32'h00000003, 8'h00, 4'd0, 1'b0, 32'h00000000, 1'b1);
    vecs[12] = mk(1'b0, 1'b1, 2'd0, 5'd0, 8'd33,  32'h00000003, 8'h00, 4'd0, 1'b0, 32'h00000000, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 2'd3, 5'd0, 8'd64,  32'h00000003, 8'h00, 4'd0, 1'b0, 32'h00000003, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 2'd0, 5'd0, 8'd0,   32'h00000003, 8'h00, 4'd0, 1'b1, 32'h00000003, 1'b1);
    vecs[15] = mk(1'b0, 1'b1, 2'd1, 5'd0, 8'd32,  32'h80000000, 8'h00, 4'd0, 1'b0, 32'h00000000, 1'b1);
    vecs[16] = mk(1'b0, 1'b1, 2'd2, 5'd0, 8'd200, 32'h80000000, 8'h00, 4'd0, 1'b0, 32'hFFFFFFFF, 1'b1);
    vecs[17] = mk(1'b0, 1'b1, 2'd3, 5'd0, 8'd4,   32'h0000000F, 8'h00, 4'd0, 1'b0, 32'hF0000000, 1'b1);
    vecs[18] = mk(1'b0, 1'b1, 2'd1, 5'd0, 8'd40,  32'hFFFFFFFF, 8'h00, 4'd0, 1'b0, 32'h00000000, 1'b0);
    vecs[19] = mk(1'b0, 1'b1, 2'd2, 5'd0, 8'd0,   32'h80000000, 8'h00, 4'd0, 1'b0, 32'h80000000, 1'b0);
    vecs[20] = mk(1'b0, 1'b1, 2'd0, 5'd0, 8'd31,  32'h00000003, 8'h00, 4'd0, 1'b0, 32'h80000000, 1'b1);
    vecs[21] = mk(1'b0, 1'b0, 2'd2, 5'd1, 8'd0,   32'h80000000, 8'h00, 4'd0, 1'b0, 32'hC0000000, 1'b0);
    vecs[22] = mk(1'b1, 1'b1, 2'd3, 5'd0, 8'd5,   32'h12345678, 8'h0F, 4'd2, 1'b0, 32'hF0000000, 1'b1);
    vecs[23] = mk(1'b0, 1'b1, 2'd3, 5'd0, 8'd33,  32'h00000003, 8'h00, 4'd0, 1'b0, 32'h80000001, 1'b1);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    apply(vecs[0], 4'd0);

    // Reset state.
    #1;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data",  {32'd0, bus.out_data}, 64'd0);
    chk("rst_cout",  {63'd0, bus.out_cout}, 64'd0);
    chk("rst_tag",   {60'd0, bus.out_tag}, 64'd0);
    chk("rst_n",     {63'd0, bus.out_n}, 64'd0);
    chk("rst_z",     {63'd0, bus.out_z}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rel_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rel_valid", {63'd0, bus.out_valid}, 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], 4'(i), $sformatf("v%0d", i));
    end

    // Back-pressure: six tagged ops, consumer stalls for three cycles mid-stream.
    sent = 0;
    rx = 0;
    saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      if (sent < 6) begin
        bp = mk(1'b0, 1'b0, 2'd0, 5'd1, 8'd0, 32'(sent + 1), 8'h00, 4'd0, 1'b0, 32'h0, 1'b0);
        apply(bp, 4'(sent));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        chk("bp_tag",  {60'd0, bus.out_tag}, 64'(rx));
        chk("bp_data", {32'd0, bus.out_data}, 64'((rx + 1) * 2));
        if (bus.out_ready) begin
          rx++;
        end
      end
      if (!bus.in_ready) begin
        saw_block = 1'b1;
      end
      if (sent < 6 && bus.in_ready) begin
        sent++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_rx",    64'(rx), 64'd6);
    chk("bp_sent",  64'(sent), 64'd6);
    chk("bp_block", {63'd0, saw_block}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_nodup", {63'd0, bus.out_valid}, 64'd0);
    end

    // Reset with two ops in flight.
    bus.out_ready = 1'b0;
    @(negedge clk);
    apply(vecs[7], 4'd7);
    bus.in_valid = 1'b1;
    @(negedge clk);
    apply(vecs[8], 4'd8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("mid_inflight", {63'd0, bus.out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_data",  {32'd0, bus.out_data}, 64'd0);
    chk("mid_rst_tag",   {60'd0, bus.out_tag}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_nostale", {63'd0, bus.out_valid}, 64'd0);
    end
    run_vec(vecs[10], 4'd9, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
